// File: rtl/stream_concat_packer.sv
`default_nettype none
// ============================================================================
// stream_concat_packer : packs COUNT narrow words, or replicates one word
// COUNT times, into a wide output word using valid/ready handshakes.
// Rev 1.0
// ============================================================================
module stream_concat_packer #(
  parameter int WIDTH     = 4,
  parameter int COUNT     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH*COUNT-1:0] out_data,
  output logic                   out_partial,
  input  logic                   out_ready
);

  localparam int                 IDX_W    = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam int                 OUT_W    = WIDTH * COUNT;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(COUNT - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] asm_q, asm_d;
  logic             grp_mode_q, grp_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_partial_q, out_partial_d;

  logic             cur_mode;
  logic             out_free;
  logic             in_fire;
  logic [OUT_W-1:0] asm_wr;

  // Mode is only sampled at the start of a group; afterwards the latched copy rules.
  assign cur_mode  = (idx_q == '0) ? mode : grp_mode_q;
  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = rst_n && (((cur_mode == 1'b0) && (idx_q != LAST_IDX)) || out_free);
  assign in_fire   = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_partial = out_partial_q;

  // Assembly image with the current word dropped into slot idx; a new group starts from zero.
  always_comb begin
    asm_wr = (idx_q == '0) ? '0 : asm_q;
    for (int k = 0; k < COUNT; k++) begin
      if (idx_q == IDX_W'(k)) begin
        if (MSB_FIRST != 0) begin
          asm_wr[(COUNT-k)*WIDTH-1 -: WIDTH] = in_data;
        end else begin
          asm_wr[k*WIDTH +: WIDTH] = in_data;
        end
      end
    end
  end

  always_comb begin
    idx_d         = idx_q;
    asm_d         = asm_q;
    grp_mode_d    = grp_mode_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (idx_q == '0) begin
        grp_mode_d = mode;
      end
      if (cur_mode) begin
        out_valid_d   = 1'b1;
        out_data_d    = {COUNT{in_data}};
        out_partial_d = 1'b0;
        idx_d         = '0;
      end else begin
        asm_d = asm_wr;
        if (idx_q == LAST_IDX) begin
          out_valid_d   = 1'b1;
          out_data_d    = asm_wr;
          out_partial_d = 1'b0;
          idx_d         = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // A completing transfer already left idx_d at zero, so it wins over flush.
    if (flush && out_free && (idx_d != '0)) begin
      out_valid_d   = 1'b1;
      out_data_d    = asm_d;
      out_partial_d = 1'b1;
      idx_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      asm_q         <= '0;
      grp_mode_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      grp_mode_q    <= grp_mode_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_partial_q <= out_partial_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_concat_packer.sv
`default_nettype none
// Directed bench: two instances (4x2 MSB-first and 8x4 LSB-first) checked against hand-computed values.
module tb_stream_concat_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_mode, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_partial, a_out_ready;
  logic [3:0] a_in_data;
  logic [7:0] a_out_data;

  logic        b_mode, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_partial, b_out_ready;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;

  stream_concat_packer #(.WIDTH(4), .COUNT(2), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .flush(a_flush), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_partial(a_out_partial), .out_ready(a_out_ready)
  );

  stream_concat_packer #(.WIDTH(8), .COUNT(4), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_partial(b_out_partial), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'h00);
    check("rst_out_partial", 32'(a_out_partial), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Concat 1010, 0101
    a_in_valid = 1'b1; a_in_data = 4'b1010; step();
    check("cat_mid_valid", 32'(a_out_valid), 32'd0);
    a_in_data = 4'b0101; step();
    a_in_valid = 1'b0;
    check("cat_valid", 32'(a_out_valid), 32'd1);
    check("cat_data", 32'(a_out_data), 32'hA5);
    check("cat_partial", 32'(a_out_partial), 32'd0);
    step();
    check("cat_valid_drop", 32'(a_out_valid), 32'd0);

    // Replicate back to back
    a_mode = 1'b1; a_in_valid = 1'b1; a_in_data = 4'b1100; #1;
    check("rep_ready0", 32'(a_in_ready), 32'd1);
    step();
    check("rep_data0", 32'(a_out_data), 32'hCC);
    a_in_data = 4'b0011; #1;
    check("rep_ready1", 32'(a_in_ready), 32'd1);
    step();
    check("rep_valid1", 32'(a_out_valid), 32'd1);
    check("rep_data1", 32'(a_out_data), 32'h33);
    a_in_valid = 1'b0; a_mode = 1'b0; step();

    // Backpressure
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 4'b1111; step();
    a_in_data = 4'b0000; step();
    check("bp_data0", 32'(a_out_data), 32'hF0);
    a_in_data = 4'b0001; #1;
    check("bp_ready_idx0", 32'(a_in_ready), 32'd1);
    step();
    check("bp_hold_valid", 32'(a_out_valid), 32'd1);
    check("bp_hold_data", 32'(a_out_data), 32'hF0);
    a_in_data = 4'b1110; #1;
    check("bp_ready_blocked", 32'(a_in_ready), 32'd0);
    step();
    check("bp_hold_data2", 32'(a_out_data), 32'hF0);
    check("bp_ready_blocked2", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1; #1;
    check("bp_ready_release", 32'(a_in_ready), 32'd1);
    step();
    a_in_valid = 1'b0;
    check("bp_final_data", 32'(a_out_data), 32'h1E);
    check("bp_final_valid", 32'(a_out_valid), 32'd1);
    step();
    check("bp_drop", 32'(a_out_valid), 32'd0);

    // Flush of a partial group
    a_in_valid = 1'b1; a_in_data = 4'b0001; step();
    a_in_valid = 1'b0; a_flush = 1'b1; step();
    a_flush = 1'b0;
    check("fl_valid", 32'(a_out_valid), 32'd1);
    check("fl_data", 32'(a_out_data), 32'h10);
    check("fl_partial", 32'(a_out_partial), 32'd1);
    a_in_valid = 1'b1; a_in_data = 4'b1010; step();
    a_in_data = 4'b0101; step();
    a_in_valid = 1'b0;
    check("fl_next_data", 32'(a_out_data), 32'hA5);
    check("fl_next_partial", 32'(a_out_partial), 32'd0);
    step();
    a_flush = 1'b1; step();
    check("fl_empty_valid", 32'(a_out_valid), 32'd0);
    a_flush = 1'b0;

    // Flush coinciding with a completing transfer
    a_in_valid = 1'b1; a_in_data = 4'b0110; step();
    a_in_data = 4'b1001; a_flush = 1'b1; step();
    a_in_valid = 1'b0;
    check("fl_cmp_data", 32'(a_out_data), 32'h69);
    check("fl_cmp_partial", 32'(a_out_partial), 32'd0);
    step();
    a_flush = 1'b0;
    check("fl_cmp_no_extra", 32'(a_out_valid), 32'd0);

    // Reset mid-group, mode toggled mid-group
    a_in_valid = 1'b1; a_in_data = 4'b1010; step();
    a_in_valid = 1'b0; rst_n = 1'b0; #1;
    check("mid_rst_ready", 32'(a_in_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    rst_n = 1'b1;
    a_in_valid = 1'b1; a_in_data = 4'b0101; step();
    a_mode = 1'b1; a_in_data = 4'b0011; step();
    a_in_valid = 1'b0; a_mode = 1'b0;
    check("mid_rst_data", 32'(a_out_data), 32'h53);
    check("mid_rst_partial", 32'(a_out_partial), 32'd0);
    step();

    // Wide LSB-first instance
    b_in_valid = 1'b1;
    b_in_data = 8'h11; step();
    b_in_data = 8'h22; step();
    b_in_data = 8'h33; step();
    check("b_mid_valid", 32'(b_out_valid), 32'd0);
    b_in_data = 8'h44; step();
    b_in_valid = 1'b0;
    check("b_cat_data", b_out_data, 32'h44332211);
    check("b_cat_valid", 32'(b_out_valid), 32'd1);
    b_mode = 1'b1; b_in_valid = 1'b1; b_in_data = 8'hA5; step();
    b_in_valid = 1'b0; b_mode = 1'b0;
    check("b_rep_data", b_out_data, 32'hA5A5A5A5);
    step();
    b_in_valid = 1'b1; b_in_data = 8'h11; step();
    b_in_data = 8'h22; step();
    b_in_valid = 1'b0; b_flush = 1'b1; step();
    b_flush = 1'b0;
    check("b_fl_data", b_out_data, 32'h00002211);
    check("b_fl_partial", 32'(b_out_partial), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_concat_packer.md
Name: stream_concat_packer

Overview:
- Sequential, handshaked successor to the combinational concatenation/replication operator block.
- Accepts a stream of WIDTH-bit words and emits COUNT*WIDTH-bit words.
- Concat mode packs COUNT successive input words into one output word, giving {w0,w1,...}.
- Replicate mode emits {COUNT{w}} for each input word.
- Adds valid/ready flow control, a partial-word flush and a configurable slot order.
- Sits between narrow producers and wide datapath consumers.

Parameters:
WIDTH, 4, bits per input word (>=1)
COUNT, 2, input words per output word / replication factor (>=2)
MSB_FIRST, 1, 1: first accepted word lands in the most significant slot; 0: least significant slot

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = concat, 1 = replicate
in_valid  input  1  input word valid
in_data  input  WIDTH  input word
in_ready  output  1  block accepts in_data this cycle
flush  input  1  emit the current partial group
out_valid  output  1  out_data valid
out_data  output  WIDTH*COUNT  packed/replicated word
out_partial  output  1  out_data came from a flush (unfilled slots zero)
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset: rst_n sampled on a clk edge. Clears out_valid, out_partial, out_data, the slot index idx and the assembly register to 0. in_ready = 0 while rst_n is low. Reset mid-group discards the partial group with no output.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Output register: separate from the assembly register. out_data and out_partial stay stable while out_valid & !out_ready. out_valid drops after the transfer unless a new word loads in the same cycle.
- Group mode: latched when a transfer occurs with idx == 0. Changes to mode mid-group are ignored until the group completes or is flushed.
- Slot mapping: slot k holds the k-th word of the group. With MSB_FIRST=1, slot k occupies bits [(COUNT-k)*WIDTH-1 -: WIDTH]. With MSB_FIRST=0, it occupies bits [k*WIDTH +: WIDTH].
- Concat transfer: the word is written to slot idx.
  - If idx < COUNT-1, idx increments.
  - If idx == COUNT-1, the completed word, including the current in_data, loads into the output register, out_partial = 0, and idx wraps to 0.
- Replicate transfer: the output register loads {COUNT{in_data}}, out_partial = 0, and idx stays 0.
- Latency: out_valid asserts on the cycle after the completing input transfer.
- in_ready:
  - In concat mode with idx < COUNT-1: 1.
  - Otherwise: (!out_valid | out_ready).
  - This gives full throughput under out_ready = 1: one output per COUNT inputs in concat mode, one per input in replicate mode.
- Flush: when flush = 1 and the group is non-empty after this cycle's transfer (idx > 0), the output register loads the assembly contents, unfilled slots 0, out_partial = 1, and idx resets to 0.
  - Flush is honoured only when (!out_valid | out_ready). Otherwise it is ignored; the requester holds flush.
  - Flush with an empty group: no effect.
  - Flush in the same cycle as a completing transfer: the normal full word is emitted with out_partial = 0.
- The assembly register is zero-filled at each new group, so partial outputs never carry stale data.
- in_data is not checked while in_valid = 0. X on in_data is not propagated unless a transfer occurs.

Test Plan:
- WIDTH=4, COUNT=2, concat, out_ready=1: 1010 then 0101 -> out_data=10100101, out_partial=0, out_valid for one cycle, one cycle after the 2nd word.
- Replicate: in_data=1100, then 0011 on consecutive cycles -> 11001100 then 00110011 on consecutive cycles; in_ready stays 1.
- Backpressure, out_ready=0: 1111, 0000 -> 11110000 held stable. 0001 is accepted (in_ready=1, idx=0). in_ready drops for 1110 until out_ready=1. Final output 00011110.
- Flush: concat, 0001 accepted, then flush=1 -> out_data=00010000, out_partial=1. A subsequent 1010, 0101 gives 10100101, out_partial=0. Flush with an empty group produces no output.
- Reset mid-group: 1010 accepted, rst_n=0 for one cycle (out_valid=0, in_ready=0). Then 0101, 0011 -> 01010011. Mode toggled mid-group is ignored.
- WIDTH=8, COUNT=4, MSB_FIRST=0: 0x11, 0x22, 0x33, 0x44 -> 0x44332211. Replicate 0xA5 -> 0xA5A5A5A5.
